// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package div_pkg;
  localparam int DIV_WIDTH_DEF = 8;
  localparam int STATE_W       = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/div_sub_step.sv
// Combinational (WIDTH+1)-bit trial subtractor: a_i + ~b_i + 1 through a full-adder ripple.
module div_sub_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  output logic [WIDTH:0] diff_o,
  output logic           neg_o
);
  logic [WIDTH:0] nb;
  logic [WIDTH:0] cy;

  assign nb    = ~b_i;
  assign cy[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign diff_o[i] = a_i[i] ^ nb[i] ^ cy[i];
    // The carry out of the top cell has no consumer; the sign lives in diff_o[WIDTH].
    if (i < WIDTH) begin : g_cy
      assign cy[i+1] = (a_i[i] & nb[i]) | (a_i[i] & cy[i]) | (nb[i] & cy[i]);
    end
  end

  assign neg_o = diff_o[WIDTH];
endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock, start/busy/done handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q;
  logic [WIDTH-1:0] a_q, q_q, d_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  // The stored remainder is always < divisor, so its WIDTH+1-th bit is implicitly zero;
  // the shift supplies the extra bit that keeps the trial sign unambiguous.
  logic [WIDTH:0]   a_sh, diff;
  logic             neg;
  logic [WIDTH-1:0] a_d, q_d;

  assign a_sh = {a_q, q_q[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_sub (
    .a_i   (a_sh),
    .b_i   ({1'b0, d_q}),
    .diff_o(diff),
    .neg_o (neg)
  );

  assign a_d = neg ? a_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_d = {q_q[WIDTH-2:0], ~neg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        // DONE accepts a new start exactly like IDLE so issue can run back-to-back.
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
              a_q     <= '0;
              q_q     <= dividend;
              d_q     <= divisor;
              cnt_q   <= CW'(WIDTH - 1);
            end
          end
        end
        CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= q_d;
            rem_q   <= a_d;
            dbz_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule
